// File: rtl/bch_encoder_op_scheduler_pkg.sv
// Shared types and helpers for the BCH encoder op scheduler: op-type and
// scheduler state encodings plus a constant-evaluable ceil(log2) helper.
package bch_encoder_op_scheduler_pkg;

    typedef enum logic [1:0] {
        OP_PASS  = 2'b00,
        OP_PAGE  = 2'b01,
        OP_SPARE = 2'b10,
        OP_RSVD  = 2'b11
    } op_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_DATA   = 2'b10,
        ST_PARITY = 2'b11
    } sched_state_e;

    function automatic int unsigned clog2_f(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic logic is_enc_op(input op_type_e op);
        return (op == OP_PAGE) || (op == OP_SPARE);
    endfunction

endpackage

// File: rtl/bch_encoder_op_scheduler_if.sv
// Bundle of the command-channel, source, sink and encoder-core signals seen by
// the scheduler; master is the environment side, slave the scheduler side.
interface bch_encoder_op_scheduler_if #(
    parameter int DataWidth          = 32,
    parameter int InnerIFLengthWidth = 16
);
    logic                            iOpQPushSignal;
    logic [InnerIFLengthWidth+1:0]   iOpQPushData;
    logic                            oOpQFull;
    logic                            oOpQOverflow;
    logic [DataWidth-1:0]            iSrcWriteData;
    logic                            iSrcWriteValid;
    logic                            iSrcWriteLast;
    logic                            oSrcWriteReady;
    logic [DataWidth-1:0]            oDstWriteData;
    logic                            oDstWriteValid;
    logic                            oDstWriteLast;
    logic                            iDstWriteReady;
    logic                            oEncClear;
    logic                            oEncDataValid;
    logic                            oEncParityShift;
    logic [DataWidth-1:0]            iEncParityData;
    logic                            oFormatError;
    logic                            oBusy;

    modport master (
        output iOpQPushSignal, iOpQPushData, iSrcWriteData, iSrcWriteValid,
               iSrcWriteLast, iDstWriteReady, iEncParityData,
        input  oOpQFull, oOpQOverflow, oSrcWriteReady, oDstWriteData,
               oDstWriteValid, oDstWriteLast, oEncClear, oEncDataValid,
               oEncParityShift, oFormatError, oBusy
    );

    modport slave (
        input  iOpQPushSignal, iOpQPushData, iSrcWriteData, iSrcWriteValid,
               iSrcWriteLast, iDstWriteReady, iEncParityData,
        output oOpQFull, oOpQOverflow, oSrcWriteReady, oDstWriteData,
               oDstWriteValid, oDstWriteLast, oEncClear, oEncDataValid,
               oEncParityShift, oFormatError, oBusy
    );
endinterface

// File: rtl/bch_encoder_op_scheduler_fifo.sv
// Op queue: small synchronous FIFO with registered full flag and a sticky
// flag recording any push that arrived while full.
module bch_op_queue_fifo
    import bch_encoder_op_scheduler_pkg::*;
#(
    parameter int Width = 18,
    parameter int Depth = 4
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iPush,
    input  logic [Width-1:0] iPushData,
    input  logic             iPop,
    output logic [Width-1:0] oPopData,
    output logic             oFull,
    output logic             oEmpty,
    output logic             oOverflow
);
    localparam int PtrW = clog2_f(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             r_full;
    logic             r_overflow;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [CntW-1:0]  w_count_nxt;

    assign w_push_ok = iPush && !r_full;
    assign w_pop_ok  = iPop && (r_count != CntW'(0));

    // Occupancy after this edge; drives the registered full flag.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CntW'(1);
            2'b01:   w_count_nxt = r_count - CntW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage, pointers, occupancy and flags.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= iPushData;
                r_wr_ptr        <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (iPush && r_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CntW'(Depth));
        end
    end

    assign oPopData  = r_mem[r_rd_ptr];
    assign oFull     = r_full;
    assign oEmpty    = (r_count == CntW'(0));
    assign oOverflow = r_overflow;
endmodule

// File: rtl/bch_encoder_op_scheduler.sv
// Pops queued {length, optype} ops and steers payload beats through the BCH
// encoder, splicing ParityBeats parity words after every codeword chunk.
module bch_encoder_op_scheduler
    import bch_encoder_op_scheduler_pkg::*;
#(
    parameter int DataWidth          = 32,
    parameter int InnerIFLengthWidth = 16,
    parameter int QueueDepth         = 4,
    parameter int ChunkBytes         = 512,
    parameter int ParityBeats        = 4
) (
    input logic                       iClock,
    input logic                       iReset,
    bch_encoder_op_scheduler_if.slave bus
);
    localparam int LenW   = InnerIFLengthWidth;
    localparam int ShiftW = clog2_f(DataWidth / 8);
    localparam int ParW   = clog2_f(ParityBeats + 1);
    localparam logic [LenW-1:0] ChunkBeatsL  = LenW'(ChunkBytes / (DataWidth / 8));
    localparam logic [ParW-1:0] ParityBeatsL = ParW'(ParityBeats);

    sched_state_e   r_state, w_state_nxt;
    op_type_e       r_optype, w_optype_nxt, w_head_type;
    logic [LenW-1:0] r_remaining, w_remaining_nxt;
    logic [LenW-1:0] r_chunk, w_chunk_nxt;
    logic [ParW-1:0] r_parity, w_parity_nxt;
    logic            r_format_error;
    logic [LenW+1:0] w_head;
    logic [LenW-1:0] w_head_beats;
    logic            w_q_full, w_q_empty, w_q_overflow, w_pop;
    logic            w_enc_op, w_xfer, w_fmt_set;
    logic            w_src_ready, w_dst_valid, w_dst_last;
    logic            w_enc_clear, w_enc_dv, w_shift;
    logic [DataWidth-1:0] w_dst_data;

    bch_op_queue_fifo #(.Width(LenW + 2), .Depth(QueueDepth)) u_op_queue (
        .iClock   (iClock),
        .iReset   (iReset),
        .iPush    (bus.iOpQPushSignal),
        .iPushData(bus.iOpQPushData),
        .iPop     (w_pop),
        .oPopData (w_head),
        .oFull    (w_q_full),
        .oEmpty   (w_q_empty),
        .oOverflow(w_q_overflow)
    );

    // A trailing partial beat is dropped by the shift.
    assign w_head_beats = w_head[LenW+1:2] >> ShiftW;
    assign w_enc_op     = is_enc_op(r_optype);
    assign w_xfer       = (r_state == ST_DATA) && bus.iSrcWriteValid && bus.iDstWriteReady;

    // Reserved optype runs as passthrough.
    always_comb begin
        w_head_type = OP_PASS;
        case (w_head[1:0])
            2'b01:   w_head_type = OP_PAGE;
            2'b10:   w_head_type = OP_SPARE;
            default: w_head_type = OP_PASS;
        endcase
    end

    // Next-state and datapath steering.
    always_comb begin
        w_state_nxt     = r_state;
        w_optype_nxt    = r_optype;
        w_remaining_nxt = r_remaining;
        w_chunk_nxt     = r_chunk;
        w_parity_nxt    = r_parity;
        w_pop           = 1'b0;
        w_fmt_set       = 1'b0;
        w_src_ready     = 1'b0;
        w_dst_valid     = 1'b0;
        w_dst_data      = '0;
        w_dst_last      = 1'b0;
        w_enc_clear     = 1'b0;
        w_enc_dv        = 1'b0;
        w_shift         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_q_empty) begin
                    w_pop           = 1'b1;
                    w_optype_nxt    = w_head_type;
                    w_remaining_nxt = w_head_beats;
                    if (w_head_beats != LenW'(0)) begin
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_enc_clear = w_enc_op;
                w_state_nxt = ST_DATA;
                if ((r_optype == OP_PAGE) && (r_remaining > ChunkBeatsL)) begin
                    w_chunk_nxt = ChunkBeatsL;
                end else begin
                    w_chunk_nxt = r_remaining;
                end
            end
            ST_DATA: begin
                w_src_ready = bus.iDstWriteReady;
                w_dst_valid = bus.iSrcWriteValid;
                w_dst_data  = bus.iSrcWriteData;
                w_dst_last  = !w_enc_op && (r_chunk == LenW'(1));
                if (w_xfer) begin
                    w_remaining_nxt = r_remaining - LenW'(1);
                    w_chunk_nxt     = r_chunk - LenW'(1);
                    w_enc_dv        = w_enc_op;
                    w_fmt_set       = bus.iSrcWriteLast ^ (r_remaining == LenW'(1));
                    if (r_chunk == LenW'(1)) begin
                        if (w_enc_op) begin
                            w_state_nxt  = ST_PARITY;
                            w_parity_nxt = ParityBeatsL;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_PARITY: begin
                w_dst_valid = 1'b1;
                w_dst_data  = bus.iEncParityData;
                w_dst_last  = (r_parity == ParW'(1)) && (r_remaining == LenW'(0));
                if (bus.iDstWriteReady) begin
                    w_shift      = 1'b1;
                    w_parity_nxt = r_parity - ParW'(1);
                    if (r_parity == ParW'(1)) begin
                        if (r_remaining == LenW'(0)) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_LOAD;
                        end
                    end else begin
                        w_state_nxt = ST_PARITY;
                    end
                end else begin
                    w_state_nxt = ST_PARITY;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Scheduler state, counters and the sticky framing flag.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            r_state        <= ST_IDLE;
            r_optype       <= OP_PASS;
            r_remaining    <= '0;
            r_chunk        <= '0;
            r_parity       <= '0;
            r_format_error <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_optype       <= w_optype_nxt;
            r_remaining    <= w_remaining_nxt;
            r_chunk        <= w_chunk_nxt;
            r_parity       <= w_parity_nxt;
            r_format_error <= r_format_error | w_fmt_set;
        end
    end

    assign bus.oOpQFull        = w_q_full;
    assign bus.oOpQOverflow    = w_q_overflow;
    assign bus.oSrcWriteReady  = w_src_ready;
    assign bus.oDstWriteData   = w_dst_data;
    assign bus.oDstWriteValid  = w_dst_valid;
    assign bus.oDstWriteLast   = w_dst_last;
    assign bus.oEncClear       = w_enc_clear;
    assign bus.oEncDataValid   = w_enc_dv;
    assign bus.oEncParityShift = w_shift;
    assign bus.oFormatError    = r_format_error;
    assign bus.oBusy           = (r_state != ST_IDLE);
endmodule

// File: tb/tb_bch_encoder_op_scheduler.sv
// Self-checking bench: expected output streams are built per op from the
// length/optype rules and compared beat by beat against the scheduler.
module tb_bch_encoder_op_scheduler;
    localparam int DW = 32;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bch_encoder_op_scheduler_if #(.DataWidth(DW), .InnerIFLengthWidth(LW)) bus_if ();

    bch_encoder_op_scheduler #(
        .DataWidth(DW), .InnerIFLengthWidth(LW), .QueueDepth(4),
        .ChunkBytes(512), .ParityBeats(4)
    ) dut (
        .iClock(clk),
        .iReset(rst_n),
        .bus   (bus_if)
    );

    typedef struct { logic [31:0] data; logic last; logic parity; logic enc; } exp_t;
    typedef struct { logic [31:0] data; logic last; } src_t;
    typedef struct { int len; int op; int beats; int clears; } vec_t;

    exp_t            exp_q[$];
    src_t            src_q[$];
    logic [LW+1:0]   push_q[$];
    vec_t            vecs[7];

    int n_checks = 0, n_fail = 0;
    int n_clear = 0, n_edv = 0, n_shift = 0, x_clear = 0, x_edv = 0, x_shift = 0;
    logic x_ferr = 1'b0, x_ovf = 1'b0;
    int par_seq = 0, next_par = 0, out_beats = 0;
    int ready_pct = 100, valid_pct = 100;
    bit pop_src = 0, do_shift = 0, prev_stall = 0;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: split an op into chunks and list every beat it must produce.
    task automatic gen_op(input int len, input int op, input int bad_idx);
        int beats, chunk_sz, done, n;
        bit enc;
        logic [31:0] w;
        beats    = len / 4;
        enc      = (op == 1) || (op == 2);
        chunk_sz = (op == 1) ? 128 : beats;
        done     = 0;
        if (bad_idx >= 0 && bad_idx != beats - 1) x_ferr = 1'b1;
        while (done < beats) begin
            n = (beats - done < chunk_sz) ? beats - done : chunk_sz;
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                src_q.push_back('{w, (done + i == beats - 1) || (done + i == bad_idx)});
                exp_q.push_back('{w, !enc && (done + i == beats - 1), 1'b0, enc});
            end
            done += n;
            if (enc) begin
                x_clear++;
                x_edv += n;
                x_shift += 4;
                for (int p = 0; p < 4; p++) begin
                    exp_q.push_back('{32'hC0DE_0000 | 32'(next_par), (p == 3) && (done == beats), 1'b1, 1'b1});
                    next_par++;
                end
            end
        end
    endtask

    task automatic push_op(input int len, input int op, input bit gen, input int bad_idx);
        logic [LW-1:0] l;
        logic [1:0]    o;
        l = len[LW-1:0];
        o = op[1:0];
        push_q.push_back({l, o});
        if (gen) gen_op(len, op, bad_idx);
    endtask

    // One clock: drive just after the rising edge, sample at the falling edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (pop_src && src_q.size() > 0) src_q.delete(0);
        if (do_shift) par_seq++;
        pop_src = 0;
        do_shift = 0;
        if (push_q.size() > 0) begin
            bus_if.iOpQPushSignal = 1'b1;
            bus_if.iOpQPushData   = push_q.pop_front();
        end else begin
            bus_if.iOpQPushSignal = 1'b0;
        end
        bus_if.iSrcWriteValid = (src_q.size() > 0) && ($urandom_range(99) < valid_pct);
        if (src_q.size() > 0) begin
            bus_if.iSrcWriteData = src_q[0].data;
            bus_if.iSrcWriteLast = src_q[0].last;
        end else begin
            bus_if.iSrcWriteData = $urandom;
            bus_if.iSrcWriteLast = 1'b0;
        end
        bus_if.iDstWriteReady = ($urandom_range(99) < ready_pct);
        bus_if.iEncParityData = 32'hC0DE_0000 | 32'(par_seq);
        @(negedge clk);
        if (prev_stall) begin
            check("parity_hold_valid", 64'(bus_if.oDstWriteValid), 64'd1);
            check("parity_hold_data", 64'(bus_if.oDstWriteData), 64'(prev_data));
        end
        if (bus_if.oEncClear) n_clear++;
        if (bus_if.oEncDataValid) n_edv++;
        if (bus_if.oEncParityShift) begin
            n_shift++;
            do_shift = 1;
        end
        if (bus_if.iSrcWriteValid && bus_if.oSrcWriteReady) pop_src = 1;
        if (bus_if.oDstWriteValid && bus_if.iDstWriteReady) begin
            out_beats++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data %0h, expected no beat", bus_if.oDstWriteData);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 64'(bus_if.oDstWriteData), 64'(e.data));
                check("beat_last", 64'(bus_if.oDstWriteLast), 64'(e.last));
                check("beat_enc_valid", 64'(bus_if.oEncDataValid), 64'(!e.parity && e.enc));
                check("beat_parity_shift", 64'(bus_if.oEncParityShift), 64'(e.parity));
            end
        end
        prev_stall = bus_if.oDstWriteValid && !bus_if.iDstWriteReady &&
                     (exp_q.size() > 0) && exp_q[0].parity;
        prev_data  = bus_if.oDstWriteData;
    endtask

    task automatic run_until_done(input string name, input int budget);
        int c;
        bit done;
        c = 0;
        done = 0;
        while (!done && c < budget) begin
            step();
            c++;
            done = (push_q.size() == 0) && (exp_q.size() == 0) && !bus_if.oBusy && (c >= 6);
        end
        check({name, "_completed"}, 64'(done), 64'd1);
    endtask

    task automatic check_counts(input string name);
        check({name, "_clear_count"}, 64'(n_clear), 64'(x_clear));
        check({name, "_encdv_count"}, 64'(n_edv), 64'(x_edv));
        check({name, "_shift_count"}, 64'(n_shift), 64'(x_shift));
        check({name, "_format_error"}, 64'(bus_if.oFormatError), 64'(x_ferr));
        check({name, "_overflow"}, 64'(bus_if.oOpQOverflow), 64'(x_ovf));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl_outputs"}, 64'({bus_if.oOpQFull, bus_if.oOpQOverflow, bus_if.oSrcWriteReady,
              bus_if.oDstWriteValid, bus_if.oDstWriteLast, bus_if.oEncClear, bus_if.oEncDataValid,
              bus_if.oEncParityShift, bus_if.oFormatError, bus_if.oBusy}), 64'd0);
        check({name, "_dst_data"}, 64'(bus_if.oDstWriteData), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_beats, base_clear, cnt;
        rst_n = 1'b0;
        bus_if.iOpQPushSignal = 1'b0;
        bus_if.iOpQPushData   = '0;
        bus_if.iSrcWriteData  = 32'hFFFF_FFFF;
        bus_if.iSrcWriteValid = 1'b1;
        bus_if.iSrcWriteLast  = 1'b0;
        bus_if.iDstWriteReady = 1'b1;
        bus_if.iEncParityData = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // {length, optype, output beats, clear pulses}, derived by hand.
        vecs[0] = '{4096, 1, 1056, 8};
        vecs[1] = '{64,   2, 20,   1};
        vecs[2] = '{40,   0, 10,   0};
        vecs[3] = '{0,    1, 0,    0};
        vecs[4] = '{43,   3, 10,   0};
        vecs[5] = '{1000, 1, 258,  2};
        vecs[6] = '{6,    2, 5,    1};
        for (int i = 0; i < 7; i++) begin
            base_beats = out_beats;
            base_clear = n_clear;
            push_op(vecs[i].len, vecs[i].op, 1'b1, -1);
            run_until_done("vector", 3000);
            check("vector_beat_total", 64'(out_beats - base_beats), 64'(vecs[i].beats));
            check("vector_clear_total", 64'(n_clear - base_clear), 64'(vecs[i].clears));
            check("vector_idle", 64'(bus_if.oBusy), 64'd0);
        end
        check_counts("table");

        ready_pct = 70;
        valid_pct = 80;
        for (int r = 0; r < 8; r++) begin
            cnt = $urandom_range(3, 1);
            for (int k = 0; k < cnt; k++) begin
                push_op($urandom_range(1100, 0), $urandom_range(3, 0), 1'b1, -1);
            end
            run_until_done("random", 8000);
        end
        check_counts("random");

        ready_pct = 35;
        valid_pct = 100;
        push_op(64, 2, 1'b1, -1);
        run_until_done("parity_stall", 2000);
        check_counts("parity_stall");

        ready_pct = 0;
        push_op(400, 0, 1'b1, -1);
        cnt = 0;
        while (!bus_if.oBusy && cnt < 20) begin
            step();
            cnt++;
        end
        check("qfull_op_started", 64'(bus_if.oBusy), 64'd1);
        push_op(8, 0, 1'b1, -1);
        push_op(12, 2, 1'b1, -1);
        push_op(16, 0, 1'b1, -1);
        push_op(4, 1, 1'b1, -1);
        push_op(20, 0, 1'b0, -1);
        for (int j = 1; j <= 6; j++) begin
            step();
            check("qfull_full", 64'(bus_if.oOpQFull), 64'(j >= 5));
            check("qfull_overflow", 64'(bus_if.oOpQOverflow), 64'(j >= 6));
        end
        x_ovf = 1'b1;
        ready_pct = 100;
        run_until_done("qfull_drain", 2000);
        check_counts("qfull");

        check("format_before", 64'(bus_if.oFormatError), 64'd0);
        base_beats = out_beats;
        push_op(64, 2, 1'b1, 2);
        run_until_done("format", 500);
        check("format_beat_total", 64'(out_beats - base_beats), 64'd20);
        check_counts("format");

        base_beats = out_beats;
        push_op(4096, 1, 1'b1, -1);
        push_op(40, 0, 1'b0, -1);
        cnt = 0;
        while ((out_beats - base_beats) < 50 && cnt < 500) begin
            step();
            cnt++;
        end
        check("midop_reached_beat50", 64'(out_beats - base_beats), 64'd50);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midop_async_reset");
        exp_q.delete();
        src_q.delete();
        push_q.delete();
        pop_src = 0;
        do_shift = 0;
        prev_stall = 0;
        par_seq = 0;
        next_par = 0;
        n_clear = 0; n_edv = 0; n_shift = 0;
        x_clear = 0; x_edv = 0; x_shift = 0;
        x_ferr = 1'b0;
        x_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("midop_reset_held");
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            check("post_reset_queue_empty", 64'(bus_if.oBusy), 64'd0);
        end
        base_beats = out_beats;
        push_op(64, 2, 1'b1, -1);
        run_until_done("post_reset_op", 500);
        check("post_reset_beat_total", 64'(out_beats - base_beats), 64'd20);
        check_counts("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
